// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done request bus between a divider client and the divider
interface seq_divider_if;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        overflow;
    logic        div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, overflow, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: 64/32 unsigned restoring divider, one quotient bit per clock
module seq_divider (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state, state_nx;
    logic [31:0] r, q, d, quo, rem;
    logic [31:0] r_nx, q_nx;
    logic [32:0] t;
    logic [4:0]  cnt;
    logic        ov, dz, bad;
    // one restoring step on the working pair, plus next-state selection
    always_comb begin
        t        = {r, q[31]} - {1'b0, d};
        r_nx     = t[32] ? {r[30:0], q[31]} : t[31:0];
        q_nx     = {q[30:0], ~t[32]};
        bad      = bus.divisor == 32'd0 || bus.dividend[63:32] >= bus.divisor;
        state_nx = state == IDLE ? (bus.start ? (bad ? DONE : CALC) : IDLE) :
                   state == CALC ? (cnt == 5'd31 ? DONE : CALC) : IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // latch operands, run iterations, publish results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            ov  <= 1'b0;
            dz  <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            dz  <= bus.divisor == 32'd0;
            ov  <= bus.divisor != 32'd0 && bus.dividend[63:32] >= bus.divisor;
            quo <= bad ? 32'hFFFF_FFFF : 32'd0;
            rem <= bus.divisor == 32'd0 ? bus.dividend[31:0] : 32'd0;
            r   <= bus.dividend[63:32];
            q   <= bus.dividend[31:0];
            d   <= bus.divisor;
            cnt <= '0;
        end else if (state == CALC) begin
            r   <= r_nx;
            q   <= q_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                quo <= q_nx;
                rem <= r_nx;
            end
        end
    end
    assign bus.ready       = state == IDLE;
    assign bus.done        = state == DONE;
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.overflow    = ov;
    assign bus.div_by_zero = dz;
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned integer divider that undoes the ALU multiplier's product: it divides a 64-bit dividend by a 32-bit divisor and returns a 32-bit quotient and a 32-bit remainder. It sits beside the ALU as a multi-cycle datapath unit. It uses a start/done handshake and a restoring shift-subtract core that retires one quotient bit per clock. Divide-by-zero and quotient overflow are detected up front and complete in one cycle.

## Interface

- No parameters; all widths are fixed (64-bit dividend, 32-bit divisor/quotient/remainder).

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a division; accepted only when ready=1
- dividend  input  64  unsigned dividend, sampled on the accepting edge
- divisor  input  32  unsigned divisor, sampled on the accepting edge
- ready  output  1  high in IDLE only (combinational from state)
- done  output  1  one-cycle pulse when results are valid
- quotient  output  32  result quotient, held until next accepted start
- remainder  output  32  result remainder, held until next accepted start
- overflow  output  1  quotient does not fit in 32 bits (divisor nonzero)
- div_by_zero  output  1  divisor was zero

## Operation

- States: IDLE, CALC, DONE.
- Reset (async, rst_n=0) forces the following values immediately: state=IDLE, quotient=0, remainder=0, done=0, overflow=0, div_by_zero=0, iteration counter=0. ready therefore reads 1.
- IDLE with start=1 accepts the request. On that same edge, quotient, remainder, overflow and div_by_zero are cleared, then the divisor is checked:
  - divisor==0: div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=dividend[31:0], go to DONE.
  - dividend[63:32] >= divisor: overflow=1, quotient=32'hFFFF_FFFF, remainder=0, go to DONE.
  - Otherwise: working remainder R(32b)=dividend[63:32], working quotient Q(32b)=dividend[31:0], counter=0, go to CALC.
- CALC iteration, once per edge, restoring algorithm:
  - T(33b) = {R, Q[31]} − {1'b0, divisor}.
  - If T is non-negative: R = T[31:0] and the new Q LSB is 1.
  - Else: R = {R[30:0], Q[31]} and the new Q LSB is 0.
  - Q shifts left by one.
  - The precheck guarantees that R < divisor always holds, so 33 bits suffice.
- After the 32nd iteration (counter==31): quotient=Q, remainder=R, go to DONE.
- DONE: done=1 for exactly this one cycle; ready=0; next edge returns to IDLE.
- start is ignored in CALC and DONE. No queuing and no error.
- Inputs may change freely after the accepting edge; only the latched copies are used.
- Reset asserted in any state aborts the operation at once. No done pulse is produced for the aborted request.

## Timing

- Accepting edge E0 (start=1, ready=1).
- Normal division:
  - CALC iterations occur on edges E1..E32.
  - State=DONE after E32, so done=1 during the cycle after E32. Latency is 32 cycles from acceptance.
- Error path: state=DONE after E0, so done=1 in the cycle immediately following acceptance.
- The earliest next acceptance is one edge after DONE, when ready=1 in IDLE. Normal back-to-back throughput is one result per 34 cycles.
- quotient, remainder and the flags are valid whenever done=1. They stay stable until the next accepting edge.

## Test plan

- Basic division: dividend=100, divisor=7, start for one cycle -> done exactly 32 cycles after the accepting edge, quotient=14, remainder=2, flags=0. ready stays 0 until after done.
- Wide dividend: dividend=64'h0000_0001_0000_0000, divisor=2 -> quotient=32'h8000_0000, remainder=0. Then dividend=64'hFFFF_FFFE_FFFF_FFFF, divisor=32'hFFFF_FFFF -> quotient=32'hFFFF_FFFF, remainder=32'hFFFF_FFFE.
- Divide by zero and overflow:
  - divisor=0, dividend=64'h1234 -> done in the next cycle, div_by_zero=1, quotient=32'hFFFF_FFFF, remainder=32'h0000_1234.
  - dividend=64'h0000_0005_0000_0000, divisor=5 -> done in the next cycle, overflow=1, quotient=32'hFFFF_FFFF, remainder=0.
- Busy protection: while in CALC for 100/7, pulse start with 50/5 -> ignored. Result is still 14/2 at the same cycle count, and exactly one done pulse occurs.
- Async reset mid-operation: assert rst_n=0 at iteration 10, between clock edges -> all outputs reset immediately and ready=1. After release, start 9/3 -> quotient=3, remainder=0, and no stale done pulse appears.
- Random regression: 10k random pairs with divisor != 0 and dividend[63:32] < divisor, compared against a reference model. Invariant checked on every result: quotient*divisor + remainder == dividend, and remainder < divisor.
